// File: rtl/ifu_fetch.sv
// Instruction fetch unit: accepts one PC at a time, issues a single memory request,
// and presents the instruction (or an alignment/bus fault) to decode.
module ifu_fetch #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  input  logic              imem_rsp_err_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_fault_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] pc_reg;
  logic [INST_W-1:0] inst_reg;
  logic              fault_reg;

  logic accept;
  logic misaligned;
  logic rsp_take;

  assign pc_ready_o       = (state_reg == IDLE) && !flush_i && !rst;
  assign accept           = pc_valid_i && pc_ready_o;
  assign misaligned       = |pc_i[1:0];
  assign rsp_take         = (state_reg == WAIT) && imem_rsp_valid_i && !flush_i;

  assign imem_req_valid_o = (state_reg == REQ);
  assign imem_req_addr_o  = pc_reg;
  assign inst_valid_o     = (state_reg == OUT);
  assign inst_o           = inst_reg;
  assign inst_pc_o        = pc_reg;
  assign inst_fault_o     = fault_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = misaligned ? OUT : REQ;
      end
      REQ: begin
        // A flush racing with req_ready still leaves a response in flight to swallow.
        if (flush_i) state_next = imem_req_ready_i ? DROP : IDLE;
        else if (imem_req_ready_i) state_next = WAIT;
      end
      WAIT: begin
        if (flush_i) state_next = imem_rsp_valid_i ? IDLE : DROP;
        else if (imem_rsp_valid_i) state_next = OUT;
      end
      OUT: begin
        if (flush_i || inst_ready_i) state_next = IDLE;
      end
      DROP: begin
        if (imem_rsp_valid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      inst_reg  <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Misaligned PCs present a zero instruction with the fault flag set.
      if (accept) begin
        pc_reg    <= pc_i;
        inst_reg  <= '0;
        fault_reg <= misaligned;
      end
      if (rsp_take) begin
        inst_reg  <= imem_rsp_data_i;
        fault_reg <= imem_rsp_err_i;
      end
    end
  end

endmodule
